keypad_timer_decoder: RTL and testbench
=======================================

// Module: keypad_timer_decoder
// PURPOSE
//  Consumer end of the keypad encoder interface. Takes the BCD key code, its
//  active-low valid strobe and the 1 Hz tick, and builds a 4-digit MM:SS cook
//  time by shifting digits in from the right. Counts the time down once per
//  tick while started, and flags completion. Drives the 7-segment display stage.
// PARAMETERS
//  SEC_WRAP_TENS  5  seconds-tens value loaded on a seconds borrow (xx:00 -> xx-1:59)
//  SEC_WRAP_ONES  9  seconds-ones value loaded on a seconds borrow
// PORTS
//  clk           in   1  system clock (same clock as the encoder)
//  clear         in   1  asynchronous, active-high reset
//  bcd_in        in   4  key code from the encoder, 0..9
//  loadn         in   1  active-low key valid; held low while a key is pressed
//  pgt_1hz       in   1  1 Hz tick level; its rising edge is one countdown step
//  startn        in   1  active-low run request (low = cook, high = pause/door open)
//  min_tens      out  4  BCD digit 3
//  min_ones      out  4  BCD digit 2
//  sec_tens      out  4  BCD digit 1
//  sec_ones      out  4  BCD digit 0
//  running       out  1  high in state COUNT
//  done          out  1  high in state DONE
//  blank         out  4  per-digit leading-zero blank, bit3 = min_tens (LEADING_ZERO_BLANK_EN only)
// BEHAVIOUR
//  - Reset (clear=1, asynchronous): all digits 0, state IDLE, running=0, done=0,
//    edge registers loadn_q=1 and tick_q=0, blank=4'b1110.
//  - Edge detect: loadn_q and tick_q are registered copies of loadn and pgt_1hz.
//    key_evt = loadn_q & ~loadn (one event per press, however long it is held).
//    tick_evt = ~tick_q & pgt_1hz.
//  - Key entry is accepted in IDLE and PAUSE only. An accepted key_evt with
//    bcd_in<=9 shifts digits left: d3<=d2, d2<=d1, d1<=d0, d0<=bcd_in. The old
//    d3 is lost. bcd_in>9 is ignored. Digits update 1 cycle after the loadn fall.
//  - States:
//    IDLE  -> PAUSE on an accepted key_evt.
//    PAUSE -> COUNT when startn=0 and the time is not 00:00.
//    COUNT -> PAUSE when startn=1. The time is retained.
//    COUNT -> DONE  on the tick_evt that leaves 00:00.
//    DONE  -> IDLE  when startn=1. The digits are already 0.
//  - Countdown (COUNT, tick_evt): decrement MM:SS as BCD.
//    If d0>0: d0--.
//    Else if d1>0: d1--, d0<=9.
//    Else if MM>0: d1<=SEC_WRAP_TENS, d0<=SEC_WRAP_ONES, and MM is decremented as
//    BCD with the same ones/tens borrow rule.
//    Entered seconds above 59 are legal and count down naturally (99 -> 98 ...).
//  - Simultaneous events:
//    key_evt in COUNT or DONE is ignored.
//    tick_evt on the same cycle as startn rising: the pause wins and no decrement happens.
//    tick_evt in PAUSE or IDLE is ignored.
//    startn=0 with 00:00 in PAUSE stays in PAUSE.
//  - clear asserted mid-count returns immediately to the reset values.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: adds the registered blank[3:0] output.
//    blank[i]=1 when digit i and all digits above it are 0. Digit 0 is never blanked.
//    Example: 00:05 -> blank=4'b1110.
//  LEADING_ZERO_BLANK_EN undefined: the blank port and its logic do not exist.
//    All other behaviour is identical.
// STRUCTURE
//  Shared package / include: state encodings ST_IDLE=2'd0, ST_PAUSE=2'd1,
//  ST_COUNT=2'd2, ST_DONE=2'd3; constant BCD_MAX=4'd9.
//  One sub-module, bcd_digit_dec: a 4-bit BCD decrementer with borrow-in,
//  borrow-out and a wrap value. It is instantiated once per digit and chained.
// TESTING
//  1. Keys 1,3,0 (each loadn low for 5 cycles) -> digits 01:30, state PAUSE,
//     exactly 3 shifts.
//  2. 01:30, startn=0, 1 tick -> 01:29. After 30 ticks -> 00:59. After 59 more
//     -> 00:00, then done=1 and running=0.
//  3. 00:10 counting, startn=1 on the tick cycle -> still 00:10, state PAUSE.
//     startn=0, 1 tick -> 00:09.
//  4. Keys 1,2,3,4,5 -> 23:45, with digit '1' dropped. bcd_in=4'hC with loadn
//     pulsed -> no change.
//  5. Keys pressed during COUNT -> digits unaffected. clear pulse mid-count ->
//     00:00, IDLE, done=0 with no clock edge needed.
//  6. LEADING_ZERO_BLANK_EN defined: 00:05 -> blank=1110; 10:00 -> blank=0000.

Source files
------------

// File: rtl/keypad_timer_decoder_pkg.sv
// keypad_timer_decoder_pkg: shared state encodings and BCD limits
package keypad_timer_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/keypad_timer_decoder_digit.sv
// bcd_digit_dec: one BCD digit decrementer; borrows out and loads wrap when it underflows
module bcd_digit_dec (
    input  logic [3:0] d,
    input  logic       bin,
    input  logic [3:0] wrap,
    output logic [3:0] q,
    output logic       bout
);

    // a borrow into a zero digit reloads the wrap value and passes the borrow upward
    always_comb begin
        bout = bin & (d == 4'd0);
        q    = bin ? (bout ? wrap : d - 4'd1) : d;
    end

endmodule

// File: rtl/keypad_timer_decoder.sv
// keypad_timer_decoder: keypad MM:SS entry, 1 Hz countdown and completion flag; LEADING_ZERO_BLANK_EN adds blank[3:0]
module keypad_timer_decoder
    import keypad_timer_decoder_pkg::*;
#(
    parameter logic [3:0] SEC_WRAP_TENS = 4'd5,
    parameter logic [3:0] SEC_WRAP_ONES = 4'd9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] bcd_in,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       startn,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [3:0] blank
`endif
);

    state_t          state_q, state_d;
    logic [3:0][3:0] dig_q, dig_d, dec, wrap;
    logic [4:0]      brw;
    logic            loadn_q, tick_q, key_evt, tick_evt, key_ok;

    assign key_evt  = loadn_q & ~loadn;
    assign tick_evt = ~tick_q & pgt_1hz;
    assign key_ok   = key_evt && (bcd_in <= BCD_MAX) && (state_q == ST_IDLE || state_q == ST_PAUSE);
    assign brw[0]   = 1'b1;
    // seconds-ones reloads 9 on a tens borrow, SEC_WRAP_ONES only when the minutes lend
    assign wrap     = {BCD_MAX, BCD_MAX, SEC_WRAP_TENS, (dig_q[1] == 4'd0) ? SEC_WRAP_ONES : BCD_MAX};

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_dec u_dec (
            .d   (dig_q[i]),
            .bin (brw[i]),
            .wrap(wrap[i]),
            .q   (dec[i]),
            .bout(brw[i+1])
        );
    end

    // brw[4] is the borrow out of the whole chain: set only when the time is 00:00
    // next state and digit updates; an accepted key takes priority over a start in PAUSE
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (key_ok) begin
                    dig_d   = {dig_q[2:0], bcd_in};
                    state_d = ST_PAUSE;
                end else if (state_q == ST_PAUSE && !startn && !brw[4]) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (startn) begin
                    state_d = ST_PAUSE;
                end else if (tick_evt) begin
                    dig_d   = dec;
                    state_d = (dec == 16'd0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_DONE: state_d = startn ? ST_IDLE : ST_DONE;
        endcase
    end

    // state, digits and input edge registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            dig_q   <= '0;
            loadn_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            loadn_q <= loadn;
            tick_q  <= pgt_1hz;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = dig_q;
    assign running = state_q == ST_COUNT;
    assign done    = state_q == ST_DONE;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] blank_q, blank_d;

    // leading-zero mask computed from the digits being registered so it stays aligned with them
    always_comb begin
        blank_d[3] = dig_d[3] == 4'd0;
        blank_d[2] = blank_d[3] && dig_d[2] == 4'd0;
        blank_d[1] = blank_d[2] && dig_d[1] == 4'd0;
        blank_d[0] = 1'b0;
    end

    // registered blank mask, all-zero time blanks the top three digits
    always_ff @(posedge clk or posedge clear) begin
        if (clear) blank_q <= 4'b1110;
        else       blank_q <= blank_d;
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_keypad_timer_decoder.sv
// tb_keypad_timer_decoder: directed scenarios plus random stimulus against a decimal MM:SS reference model
module tb_keypad_timer_decoder;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] bcd_in = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt_1hz = 1'b0;
    logic       startn = 1'b1;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] blank;
`endif

    int total = 0;
    int bad = 0;

    keypad_timer_decoder dut (
        .clk     (clk),
        .clear   (clear),
        .bcd_in  (bcd_in),
        .loadn   (loadn),
        .pgt_1hz (pgt_1hz),
        .startn  (startn),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running (running),
        .done    (done)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank   (blank)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_PAUSE, M_COUNT, M_DONE} mst_t;
    mst_t m_st = M_IDLE;
    int   m_n = 0;
    bit   m_lp = 1'b1;
    bit   m_tp = 1'b0;

    function automatic logic [15:0] dig();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        r[15:12] = 4'(n / 1000);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic int time_dec(int n);
        int mm, ss;
        mm = n / 100;
        ss = n % 100;
        if (ss > 0) ss--;
        else if (mm > 0) begin
            mm--;
            ss = 59;
        end
        return mm * 100 + ss;
    endfunction

    function automatic logic [3:0] blank_of(int n);
        return {n < 1000, n < 100, n < 10, 1'b0};
    endfunction

    task automatic model_step();
        bit kev, tev;
        if (clear) begin
            m_n = 0; m_st = M_IDLE; m_lp = 1'b1; m_tp = 1'b0;
            return;
        end
        kev = m_lp && !loadn;
        tev = !m_tp && pgt_1hz;
        m_lp = loadn;
        m_tp = pgt_1hz;
        case (m_st)
            M_IDLE, M_PAUSE: begin
                if (kev && bcd_in <= 4'd9) begin
                    m_n = (m_n * 10 + int'(bcd_in)) % 10000;
                    m_st = M_PAUSE;
                end else if (m_st == M_PAUSE && !startn && m_n != 0) m_st = M_COUNT;
            end
            M_COUNT: begin
                if (startn) m_st = M_PAUSE;
                else if (tev) begin
                    m_n = time_dec(m_n);
                    if (m_n == 0) m_st = M_DONE;
                end
            end
            M_DONE: if (startn) m_st = M_IDLE;
        endcase
    endtask

    task automatic cycle(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic press(logic [3:0] k);
        bcd_in = k;
        loadn = 1'b0;
        cycle(5);
        loadn = 1'b1;
        cycle(2);
    endtask

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            pgt_1hz = 1'b1;
            cycle(3);
            pgt_1hz = 1'b0;
            cycle(3);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        cycle(2);
        total++; if (dig() !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h want=0000", dig()); end
        total++; if ({running, done} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {running, done}); end
`ifdef LEADING_ZERO_BLANK_EN
        total++; if (blank !== 4'b1110) begin bad++; $display("FAIL reset_blank got=%b want=1110", blank); end
`endif
        clear = 1'b0;
        cycle();
    endtask

    task automatic test_entry();
        press(4'd1); press(4'd3); press(4'd0);
        total++; if (dig() !== 16'h0130) begin bad++; $display("FAIL entry_digits got=%h want=0130", dig()); end
        total++; if ({running, done} !== 2'b00) begin bad++; $display("FAIL entry_flags got=%b want=00", {running, done}); end
    endtask

    task automatic test_countdown();
        startn = 1'b0;
        cycle();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL count_running got=%b want=1", running); end
        tick();
        total++; if (dig() !== 16'h0129) begin bad++; $display("FAIL count_first got=%h want=0129", dig()); end
        tick(30);
        total++; if (dig() !== 16'h0059) begin bad++; $display("FAIL count_min_borrow got=%h want=0059", dig()); end
        tick(59);
        total++; if (dig() !== 16'h0000) begin bad++; $display("FAIL count_zero got=%h want=0000", dig()); end
        total++; if ({running, done} !== 2'b01) begin bad++; $display("FAIL count_done got=%b want=01", {running, done}); end
        startn = 1'b1;
        cycle();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_release got=%b want=0", done); end
    endtask

    task automatic test_pause_tick();
        press(4'd1); press(4'd0);
        startn = 1'b0;
        cycle(2);
        pgt_1hz = 1'b1;
        startn = 1'b1;
        cycle();
        total++; if (dig() !== 16'h0010) begin bad++; $display("FAIL pause_wins got=%h want=0010", dig()); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_state got=%b want=0", running); end
        pgt_1hz = 1'b0;
        cycle(3);
        startn = 1'b0;
        cycle(2);
        tick();
        total++; if (dig() !== 16'h0009) begin bad++; $display("FAIL resume_tick got=%h want=0009", dig()); end
    endtask

    task automatic test_overflow();
        startn = 1'b1;
        cycle();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        total++; if (dig() !== 16'h2345) begin bad++; $display("FAIL shift_drop got=%h want=2345", dig()); end
        press(4'hC);
        total++; if (dig() !== 16'h2345) begin bad++; $display("FAIL bad_code got=%h want=2345", dig()); end
    endtask

    task automatic test_count_keys();
        startn = 1'b0;
        cycle(2);
        tick();
        total++; if (dig() !== 16'h2344) begin bad++; $display("FAIL tick_2345 got=%h want=2344", dig()); end
        press(4'd7);
        total++; if (dig() !== 16'h2344) begin bad++; $display("FAIL key_in_count got=%h want=2344", dig()); end
        @(negedge clk);
        #2 clear = 1'b1;
        #1;
        total++; if (dig() !== 16'h0000) begin bad++; $display("FAIL async_clear got=%h want=0000", dig()); end
        total++; if ({running, done} !== 2'b00) begin bad++; $display("FAIL async_clear_flags got=%b want=00", {running, done}); end
        cycle();
        clear = 1'b0;
        startn = 1'b1;
        cycle();
    endtask

    task automatic test_zero_pause();
        press(4'd0);
        startn = 1'b0;
        cycle(3);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL zero_start got=%b want=0", running); end
        startn = 1'b1;
        do_clear();
    endtask

    task automatic test_blank();
        press(4'd5);
        total++; if (dig() !== 16'h0005) begin bad++; $display("FAIL blank_entry got=%h want=0005", dig()); end
`ifdef LEADING_ZERO_BLANK_EN
        total++; if (blank !== 4'b1110) begin bad++; $display("FAIL blank_0005 got=%b want=1110", blank); end
`endif
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        total++; if (dig() !== 16'h1000) begin bad++; $display("FAIL blank_entry2 got=%h want=1000", dig()); end
`ifdef LEADING_ZERO_BLANK_EN
        total++; if (blank !== 4'b0000) begin bad++; $display("FAIL blank_1000 got=%b want=0000", blank); end
`endif
        do_clear();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) loadn = ~loadn;
            if ($urandom_range(0, 3) == 0) bcd_in = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) pgt_1hz = ~pgt_1hz;
            if ($urandom_range(0, 39) == 0) startn = ~startn;
            clear = ($urandom_range(0, 599) == 0);
            cycle();
            total++; if (dig() !== to_bcd(m_n)) begin bad++; $display("FAIL rand_digits cyc=%0d got=%h want=%h", i, dig(), to_bcd(m_n)); end
            total++; if ({running, done} !== {m_st == M_COUNT, m_st == M_DONE}) begin bad++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", i, {running, done}, {m_st == M_COUNT, m_st == M_DONE}); end
`ifdef LEADING_ZERO_BLANK_EN
            total++; if (blank !== blank_of(m_n)) begin bad++; $display("FAIL rand_blank cyc=%0d got=%b want=%b", i, blank, blank_of(m_n)); end
`endif
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_pause_tick();
        test_overflow();
        test_count_keys();
        test_zero_pause();
        test_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
